// File: rtl/serial_pkg.sv
// Shared definitions for the serial arithmetic units.
// Contents:
//   state_t             - controller state encoding (IDLE, RUN, DONE)
//   MODE_ADD / MODE_SUB - values of the mode input
//   fa_sum / fa_carry   - single-bit full-adder helpers used by the datapath
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Full-adder sum bit
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Full-adder carry bit (majority of the three inputs)
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

endpackage

// File: rtl/serial_carry_reg.sv
// Single-bit carry flop for the bit-serial datapath.
// Ports:
//   clk_i   - rising-edge clock
//   clr_n_i - asynchronous active-low clear
//   load_i  - synchronous load of init_i (has priority over en_i)
//   init_i  - value loaded when load_i is high
//   en_i    - synchronous update with d_i
//   d_i     - next carry value
//   q_o     - registered carry
module serial_carry_reg (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic load_i,
    input  logic init_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    // Carry storage: clear, load, update or hold
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            q_o <= 1'b0;
        end else if (load_i) begin
            q_o <= init_i;
        end else if (en_i) begin
            q_o <= d_i;
        end else begin
            q_o <= q_o;
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor with start/done handshake.
// Operands are captured on an accepted start and processed LSB-first, one
// bit per clock. Subtraction is a + ~b + 1 (carry preset to 1).
// Ports:
//   clk   - rising-edge clock
//   clr_n - asynchronous active-low reset
//   start - request an operation (only honoured in IDLE)
//   mode  - 0 = add, 1 = subtract
//   abort - cancel a running operation (RUN only)
//   a, b  - operands, captured on start accept
//   sum   - result, held until the next completed operation or reset
//   cout  - final carry (subtract: 1 = no borrow)
//   ovf   - signed overflow
//   busy  - high in RUN and DONE
//   done  - one-cycle pulse when the result is valid
module serial_addsub
    import serial_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rega_q, rega_d;
    logic [WIDTH-1:0]   regb_q, regb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, done_q;
    logic               carry_q;
    logic               carry_load_s;
    logic               carry_init_s;
    logic               carry_en_s;
    logic               bit_s;
    logic               carry_nxt_s;

    assign bit_s       = fa_sum(rega_q[0], regb_q[0], carry_q);
    assign carry_nxt_s = fa_carry(rega_q[0], regb_q[0], carry_q);

    serial_carry_reg u_carry (
        .clk_i   (clk),
        .clr_n_i (clr_n),
        .load_i  (carry_load_s),
        .init_i  (carry_init_s),
        .en_i    (carry_en_s),
        .d_i     (carry_nxt_s),
        .q_o     (carry_q)
    );

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        rega_d       = rega_q;
        regb_d       = regb_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        carry_load_s = 1'b0;
        carry_init_s = (mode == MODE_SUB);
        carry_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // start has priority over abort here; abort is meaningless in IDLE
                if (start) begin
                    rega_d       = a;
                    regb_d       = (mode == MODE_ADD) ? b : ~b;
                    cnt_d        = {CNT_W{1'b0}};
                    carry_load_s = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    rega_d     = {bit_s, rega_q[WIDTH-1:1]};
                    regb_d     = {1'b0, regb_q[WIDTH-1:1]};
                    carry_en_s = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // carry_q is the carry into the MSB on this last bit
                        sum_d   = {bit_s, rega_q[WIDTH-1:1]};
                        cout_d  = carry_nxt_s;
                        ovf_d   = carry_q ^ carry_nxt_s;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            rega_q  <= {WIDTH{1'b0}};
            regb_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         clr_n;
    logic         start;
    logic         mode;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .mode  (mode),
        .abort (abort),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (clr_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum",  {24'd0, sum}, {24'd0, e.s});
                check("cout", {31'd0, cout}, {31'd0, e.c});
                check("ovf",  {31'd0, ovf}, {31'd0, e.o});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one start pulse; push the expected result when a done is due
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m,
                         input bit push, input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        a = av; b = bv; mode = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.s = es; e.c = ec; e.o = eo; e.cyc = cyc + W;
            sb.push_back(e);
        end
    endtask

    // Count busy cycles until IDLE, with a bound
    task automatic wait_idle(output int n);
        bit ok;
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) begin
                n++;
            end else begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m,
                      input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        issue(av, bv, m, 1'b1, es, ec, eo);
        wait_idle(n);
        check("busy_len", n, W + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        exp_t e;
        clr_n = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; a = '0; b = '0;
        #2 clr_n = 1'b0;
        #10;
        check("rst_sum",  {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf",  {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        // Directed vectors
        op(8'h3A, 8'h25, 1'b0, 8'h5F, 1'b0, 1'b0);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        op(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);
        op(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1);

        // Start during RUN is ignored; operand changes have no effect
        issue(8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'hFF; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Async clear in the middle of RUN
        issue(8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("clr_sum",  {24'd0, sum}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("clr_idle_busy", {31'd0, busy}, 32'd0);

        // Abort in RUN keeps the previous result
        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue(8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum",  {24'd0, sum}, 32'h80);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_ovf",  {31'd0, ovf}, 32'd1);
        repeat (W + 4) @(negedge clk);

        // Back-to-back with start held: done every W+2 cycles
        @(negedge clk);
        a = 8'h01; b = 8'h01; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        acc0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e.s = 8'h02; e.c = 1'b0; e.o = 1'b0; e.cyc = acc0 + k * (W + 2) + W;
            sb.push_back(e);
        end
        repeat (2 * (W + 2)) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(n);
        check("b2b_last_busy", n, W + 1);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
